// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the instruction-fetch front
//                end. Holds the fetch FSM state type and the buffered
//                {instruction, pc} entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Small synchronous FIFO of fetch entries with push, pop and
//                flush. The head entry is read straight out of the storage
//                registers, so it is stable while nothing is popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  fetch_entry_t                   i_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output fetch_entry_t                   o_head,
    output logic [$clog2(DEPTH + 1)-1:0]   o_count,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW   = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_pop;

    // Popping an empty FIFO is ignored so the count can never underflow.
    assign w_pop = i_pop && (r_count != '0);

    // Pointer increment that wraps for any depth, not just powers of two.
    function automatic logic [c_AW-1:0] f_next(input logic [c_AW-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + c_AW'(1);
    endfunction

    // Storage, pointers and occupancy; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            r_count <= r_count + c_CW'(i_push) - c_CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Owns the PC, issues in-order
//                word reads to instruction memory, buffers returned words
//                and hands {instruction, pc} to decode. A redirect from
//                decode restarts fetch and discards all in-flight reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int              BUF_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_misaligned
);

    localparam int              c_CW  = $clog2(BUF_DEPTH + 1);
    localparam logic [c_CW:0]   c_CAP = (c_CW + 1)'(BUF_DEPTH);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic            r_req_valid;
    logic            r_misaligned;

    logic            w_req_fire;
    logic            w_resp_fire;
    logic            w_deq;
    logic            w_buf_push;
    logic [c_CW-1:0] w_outstanding_next;
    logic [c_CW-1:0] w_count_next;
    logic [c_CW:0]   w_level_next;

    fetch_entry_t    w_buf_wdata;
    fetch_entry_t    w_buf_head;
    logic [c_CW-1:0] w_buf_count;
    logic            w_buf_full;
    logic            w_buf_empty;

    fetch_entry_t    w_tag_wdata;
    fetch_entry_t    w_tag_head;
    logic [c_CW-1:0] w_tag_count;
    logic            w_tag_full;
    logic            w_tag_empty;

    // A response with nothing outstanding is a leftover from before reset.
    assign w_req_fire  = r_req_valid & imem_req_ready;
    assign w_resp_fire = imem_resp_valid & (r_outstanding != '0);
    assign w_deq       = inst_valid & inst_ready;
    assign w_buf_push  = w_resp_fire & (r_drop_cnt == '0) & ~redirect;

    // Next-cycle occupancy drives the registered issue decision, so the
    // request valid never has a combinational path from redirect.
    assign w_outstanding_next = r_outstanding + c_CW'(w_req_fire) - c_CW'(w_resp_fire);
    assign w_count_next       = redirect ? '0
                              : (w_buf_count + c_CW'(w_buf_push) - c_CW'(w_deq));
    assign w_level_next       = {1'b0, w_outstanding_next} + {1'b0, w_count_next};

    assign w_tag_wdata = '{instr: '0, pc: r_pc};
    assign w_buf_wdata = '{instr: imem_resp_data, pc: w_tag_head.pc};

    // Tag queue: pc of every issued read, popped by every response (kept or
    // dropped) so tags stay aligned with the in-order response stream.
    fetch_buffer #(
        .DEPTH   (BUF_DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_data  (w_tag_wdata),
        .i_pop   (w_resp_fire),
        .i_flush (1'b0),
        .o_head  (w_tag_head),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    // Instruction buffer presented to decode; a redirect empties it.
    fetch_buffer #(
        .DEPTH   (BUF_DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_buf_push),
        .i_data  (w_buf_wdata),
        .i_pop   (w_deq),
        .i_flush (redirect),
        .o_head  (w_buf_head),
        .o_count (w_buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    // Fetch FSM, PC, in-flight/drop counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_req_valid   <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN:  r_state <= RUN;
            endcase
            r_req_valid   <= (w_level_next < c_CAP);
            r_outstanding <= w_outstanding_next;
            r_misaligned  <= redirect & (|redirect_target[1:0]);
            if (redirect) begin
                // Every read still in flight after this edge belongs to the
                // old path, including one accepted in this very cycle.
                r_pc       <= {redirect_target[XLEN-1:2], 2'b00};
                r_drop_cnt <= w_outstanding_next;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_resp_fire && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_CW'(1);
                end
            end
        end
    end

    assign imem_req_valid   = r_req_valid;
    assign imem_req_addr    = r_pc;
    assign inst_valid       = ~w_buf_empty;
    assign instruction      = w_buf_head.instr;
    assign inst_pc          = w_buf_head.pc;
    assign fetch_misaligned = r_misaligned;

    // The issue rule reserves a buffer slot for every read in flight.
    a_buf_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_buf_push && w_buf_full && !w_deq));
    a_tag_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_req_fire && w_tag_full && !w_resp_fire));
    a_tag_tracking : assert property (@(posedge clk) disable iff (!rst_n)
        (w_tag_count == r_outstanding) && (w_tag_empty == (r_outstanding == '0))
        && (w_tag_head.instr == '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A memory model with
//                configurable latency answers requests; expected decode
//                entries are queued when responses are driven and compared
//                when decode consumes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RV        = 32'h0000_0000;
    localparam logic [31:0] RV2       = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_misaligned;

    logic        req2_valid;
    logic        req2_ready = 1'b1;
    logic [31:0] req2_addr;
    logic        resp2_valid = 1'b0;
    logic [31:0] resp2_data = '0;
    logic        inst2_valid;
    logic        inst2_ready = 1'b0;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        redir2 = 1'b0;
    logic [31:0] redir2_target = '0;
    logic        mis2;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          since_rel = 0;
    int          epoch = 0;
    int          n_req = 0;
    int          lat = 1;
    bit          rand_ready = 1'b0;
    bit          inject = 1'b0;
    bit          started = 1'b0;
    logic [31:0] exp_pc = RV;
    logic        exp_mis = 1'b0;

    mem_req_t     pending[$];
    fetch_entry_t sb[$];
    logic [31:0]  dlog[$];
    logic [31:0]  addr2_log[$];

    fetch_unit #(
        .RESET_VECTOR     (RV),
        .BUF_DEPTH        (BUF_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .instruction      (instruction),
        .inst_pc          (inst_pc),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .fetch_misaligned (fetch_misaligned)
    );

    fetch_unit #(
        .RESET_VECTOR     (RV2),
        .BUF_DEPTH        (BUF_DEPTH)
    ) dut_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (req2_valid),
        .imem_req_ready   (req2_ready),
        .imem_req_addr    (req2_addr),
        .imem_resp_valid  (resp2_valid),
        .imem_resp_data   (resp2_data),
        .inst_valid       (inst2_valid),
        .inst_ready       (inst2_ready),
        .instruction      (instr2),
        .inst_pc          (pc2),
        .redirect         (redir2),
        .redirect_target  (redir2_target),
        .fetch_misaligned (mis2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rel <= 0;
        else        since_rel <= since_rel + 1;
    end

    // Memory model: in-order responses once the latency has elapsed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = 32'hBAD0_0BAD;
            end else if (pending.size() != 0 && pending[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pending[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Monitor and scoreboard, evaluated mid-cycle on the values the DUT sees.
    always @(negedge clk) begin
        mem_req_t     pe;
        fetch_entry_t se;
        if (started && rst_n) begin
            if (since_rel == 0)
                check("req_valid_boot", {31'b0, imem_req_valid}, 32'd0);
            else
                check("req_valid_cap", {31'b0, imem_req_valid},
                      {31'b0, ((pending.size() + sb.size()) < BUF_DEPTH)});
            check("inst_valid", {31'b0, inst_valid}, {31'b0, (sb.size() != 0)});
            check("misaligned", {31'b0, fetch_misaligned}, {31'b0, exp_mis});
            exp_mis = redirect && (redirect_target[1:0] != 2'b00);
            if (inst_valid && sb.size() != 0) begin
                check("head_pc", inst_pc, sb[0].pc);
                check("head_instr", instruction, sb[0].instr);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                pe = '{addr: imem_req_addr, ep: epoch, due: cyc + lat};
                pending.push_back(pe);
                exp_pc = exp_pc + 32'd4;
                n_req++;
            end
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    check("deq_expected", {31'b0, (sb.size() != 0)}, 32'd1);
                end else begin
                    se = sb.pop_front();
                    dlog.push_back(se.pc);
                end
            end
            if (redirect) begin
                epoch++;
                sb.delete();
                dlog.delete();
                exp_pc = {redirect_target[31:2], 2'b00};
            end
            if (imem_resp_valid && !inject && pending.size() != 0) begin
                pe = pending.pop_front();
                if (pe.ep == epoch) begin
                    se = '{instr: mem_word(pe.addr), pc: pe.addr};
                    sb.push_back(se);
                end
            end
            if (req2_valid && req2_ready) addr2_log.push_back(req2_addr);
        end
    end

    task automatic do_reset(input bit inj);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        started = 1'b1;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RV);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
        check("rst_wrap_addr", req2_addr, RV2);
        pending.delete();
        sb.delete();
        dlog.delete();
        addr2_log.delete();
        exp_pc   = RV;
        exp_mis  = 1'b0;
        epoch++;
        n_req    = 0;
        redirect = 1'b0;
        inject   = inj;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        inject = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect        = 1'b1;
        redirect_target = target;
        @(posedge clk);
        #2;
        redirect = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (dlog.size() >= n) break;
        end
        check("deliveries_seen", (dlog.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit;

        // 1: streaming from reset with single-cycle memory
        lat = 1; inst_ready = 1'b1; rand_ready = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (inst_valid) break;
        end
        check("first_valid_cycle", since_rel, 32'd3);
        wait_log(6, 30);
        for (int i = 0; i < 6; i++) check("stream_pc", dlog[i], 32'(i * 4));
        check("wrap_req_count", addr2_log.size(), 32'd2);
        if (addr2_log.size() >= 2) begin
            check("wrap_first_addr", addr2_log[0], 32'hFFFF_FFFC);
            check("wrap_second_addr", addr2_log[1], 32'h0000_0000);
        end

        // 2: decode stalls, buffer fills and issue stops
        inst_ready = 1'b0;
        do_reset(1'b0);
        repeat (10) begin
            @(negedge clk);
        end
        #1;
        check("stall_req_count", n_req, 32'd2);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("stall_hold_pc", inst_pc, 32'h0);
        @(posedge clk);
        #2;
        inst_ready = 1'b1;
        wait_log(2, 10);
        check("release_pc0", dlog[0], 32'h0);
        check("release_pc1", dlog[1], 32'h4);

        // 3: redirect with two reads in flight on a slow memory
        lat = 3;
        do_reset(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = (pending.size() == 2);
        end
        check("two_in_flight", {31'b0, hit}, 32'd1);
        do_redirect(32'h0000_0100);
        wait_log(2, 40);
        check("redir_pc0", dlog[0], 32'h100);
        check("redir_pc1", dlog[1], 32'h104);

        // 4: redirect coinciding with a response and an accepted request
        lat = 1;
        do_reset(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = imem_resp_valid && imem_req_valid && imem_req_ready;
        end
        check("coincident_found", {31'b0, hit}, 32'd1);
        do_redirect(32'h0000_0200);
        wait_log(2, 20);
        check("coinc_pc0", dlog[0], 32'h200);
        check("coinc_pc1", dlog[1], 32'h204);

        // 5: misaligned redirect target
        @(posedge clk);
        #2;
        do_redirect(32'h0000_0106);
        @(negedge clk);
        #1;
        check("mis_pulse_hi", {31'b0, fetch_misaligned}, 32'd1);
        @(negedge clk);
        #1;
        check("mis_pulse_lo", {31'b0, fetch_misaligned}, 32'd0);
        wait_log(2, 20);
        check("mis_pc0", dlog[0], 32'h104);
        check("mis_pc1", dlog[1], 32'h108);

        // 6: random back-pressure, then reset mid-stream with stale responses
        lat = 2; rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            inst_ready = 1'($urandom_range(0, 1));
        end
        inst_ready = 1'b1;
        do_reset(1'b1);
        wait_log(3, 60);
        check("restart_pc0", dlog[0], RV);
        check("restart_pc1", dlog[1], RV + 32'd4);
        check("restart_pc2", dlog[2], RV + 32'd8);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
